// File: rtl/ram_dp_clr.sv
// Dual-port RAM with byte-lane writes, registered read, write-first forwarding.
// After reset, or on a clear pulse, a hardware sweep zeroes every word.
module ram_dp_clr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic [DATA_WIDTH-1:0]   ram_out,
    output logic                    read_valid,
    output logic                    busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_CLEAR = 1'b1;

    logic                  state;
    logic [ADDR_WIDTH-1:0] clrCount;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acceptAccess;
    logic                  writeAccept;
    logic                  readAccept;
    logic [DATA_WIDTH-1:0] oldWord;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic [DATA_WIDTH-1:0] readWord;

    // The cycle that requests a clear is swallowed along with any user access.
    assign acceptAccess = (state == STATE_IDLE) && !clear;
    assign writeAccept  = acceptAccess && we && (|byte_en);
    assign readAccept   = acceptAccess && re;
    assign busy         = (state == STATE_CLEAR);
    assign oldWord      = mem[write_addr];

    always_comb begin
        mergedWord = oldWord;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_en[i]) begin
                mergedWord[8*i +: 8] = data[8*i +: 8];
            end
        end
    end

    // Write-first: a same-address read sees the lanes being written this edge.
    always_comb begin
        readWord = mem[read_addr];
        if (writeAccept && (write_addr == read_addr)) begin
            readWord = mergedWord;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= STATE_CLEAR;
            clrCount <= '0;
        end else begin
            case (state)
                STATE_CLEAR: begin
                    if (clrCount == '1) begin
                        state    <= STATE_IDLE;
                        clrCount <= '0;
                    end else begin
                        clrCount <= clrCount + 1'b1;
                    end
                end
                default: begin
                    if (clear) begin
                        state    <= STATE_CLEAR;
                        clrCount <= '0;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; it is zeroed only by the sweep.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (state == STATE_CLEAR) begin
                mem[clrCount] <= '0;
            end else if (writeAccept) begin
                mem[write_addr] <= mergedWord;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_out    <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= readAccept;
            if (readAccept) begin
                ram_out <= readWord;
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed testbench for ram_dp_clr with hand-computed expected values.
module tb_ram_dp_clr;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  byte_en = 4'h0;
    logic [5:0]  write_addr = 6'd0;
    logic [31:0] data = 32'h0;
    logic        re = 1'b0;
    logic [5:0]  read_addr = 6'd0;
    logic [31:0] ram_out;
    logic        read_valid;
    logic        busy;

    int vecCount = 0;
    int missCount = 0;

    ram_dp_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .we(we),
        .byte_en(byte_en), .write_addr(write_addr), .data(data),
        .re(re), .read_addr(read_addr), .ram_out(ram_out),
        .read_valid(read_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; write_addr = a; data = d; byte_en = be;
        @(negedge clock);
        we = 1'b0; byte_en = 4'h0;
    endtask

    task automatic do_read(input logic [5:0] a);
        re = 1'b1; read_addr = a;
        @(negedge clock);
        re = 1'b0;
    endtask

    // Counts edges until busy drops; sweep should take 64 edges.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        repeat (3) @(negedge clock);
        vecCount++;
        if ({busy, read_valid, ram_out} !== {1'b1, 1'b0, 32'h0}) begin
            missCount++;
            $display("[TB] FAIL reset_outputs: got busy=%b rv=%b out=%h expected busy=1 rv=0 out=00000000",
                     busy, read_valid, ram_out);
        end
        reset_n = 1'b1;
        count_busy(n);
        vecCount++;
        if (n !== 64) begin
            missCount++;
            $display("[TB] FAIL reset_busy_len: got %0d expected 64", n);
        end
    endtask

    task automatic test_clear_contents;
        for (int i = 0; i < 64; i++) begin
            do_read(6'(i));
            vecCount++;
            if ({read_valid, ram_out} !== {1'b1, 32'h0}) begin
                missCount++;
                $display("[TB] FAIL zero_read[%0d]: got rv=%b out=%h expected rv=1 out=00000000",
                         i, read_valid, ram_out);
            end
        end
        @(negedge clock);
        vecCount++;
        if (read_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL rv_idle: got %b expected 0", read_valid);
        end
    endtask

    task automatic test_byte_write;
        do_write(6'd5, 32'hDEADBEEF, 4'b1111);
        do_write(6'd5, 32'h11223344, 4'b0101);
        do_read(6'd5);
        vecCount++;
        if ({read_valid, ram_out} !== {1'b1, 32'hDE22BE44}) begin
            missCount++;
            $display("[TB] FAIL byte_write: got rv=%b out=%h expected rv=1 out=de22be44", read_valid, ram_out);
        end
        @(negedge clock);
        vecCount++;
        if ({read_valid, ram_out} !== {1'b0, 32'hDE22BE44}) begin
            missCount++;
            $display("[TB] FAIL read_hold: got rv=%b out=%h expected rv=0 out=de22be44", read_valid, ram_out);
        end
    endtask

    task automatic test_zero_mask;
        do_write(6'd5, 32'hFFFFFFFF, 4'b0000);
        do_read(6'd5);
        vecCount++;
        if (ram_out !== 32'hDE22BE44) begin
            missCount++;
            $display("[TB] FAIL zero_mask: got %h expected de22be44", ram_out);
        end
    endtask

    task automatic test_forwarding;
        do_write(6'd9, 32'h12345678, 4'b1111);
        we = 1'b1; write_addr = 6'd9; data = 32'hCAFEF00D; byte_en = 4'b0011;
        re = 1'b1; read_addr = 6'd9;
        @(negedge clock);
        we = 1'b0; re = 1'b0; byte_en = 4'h0;
        vecCount++;
        if ({read_valid, ram_out} !== {1'b1, 32'h1234F00D}) begin
            missCount++;
            $display("[TB] FAIL forward: got rv=%b out=%h expected rv=1 out=1234f00d", read_valid, ram_out);
        end
        do_read(6'd9);
        vecCount++;
        if (ram_out !== 32'h1234F00D) begin
            missCount++;
            $display("[TB] FAIL forward_stored: got %h expected 1234f00d", ram_out);
        end
    endtask

    task automatic test_independent;
        we = 1'b1; write_addr = 6'd20; data = 32'hAABBCCDD; byte_en = 4'b1111;
        re = 1'b1; read_addr = 6'd5;
        @(negedge clock);
        we = 1'b0; re = 1'b0; byte_en = 4'h0;
        vecCount++;
        if (ram_out !== 32'hDE22BE44) begin
            missCount++;
            $display("[TB] FAIL indep_read: got %h expected de22be44", ram_out);
        end
        do_read(6'd20);
        vecCount++;
        if (ram_out !== 32'hAABBCCDD) begin
            missCount++;
            $display("[TB] FAIL indep_write: got %h expected aabbccdd", ram_out);
        end
    endtask

    task automatic test_clear_pulse;
        int n;
        logic [5:0] addrs [3];
        addrs[0] = 6'd5; addrs[1] = 6'd33; addrs[2] = 6'd40;
        clear = 1'b1;
        we = 1'b1; write_addr = 6'd33; data = 32'h55555555; byte_en = 4'b1111;
        re = 1'b1; read_addr = 6'd5;
        @(negedge clock);
        clear = 1'b0; write_addr = 6'd40; data = 32'h66666666; read_addr = 6'd20;
        n = 0;
        while (busy && n < 200) begin
            n++;
            vecCount++;
            if (read_valid !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL busy_rv[%0d]: got %b expected 0", n, read_valid);
            end
            clear = (n == 10);
            @(negedge clock);
        end
        clear = 1'b0; we = 1'b0; re = 1'b0; byte_en = 4'h0;
        vecCount++;
        if (n !== 64) begin
            missCount++;
            $display("[TB] FAIL clear_busy_len: got %0d expected 64", n);
        end
        vecCount++;
        if (ram_out !== 32'hAABBCCDD) begin
            missCount++;
            $display("[TB] FAIL clear_hold_out: got %h expected aabbccdd", ram_out);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(addrs[i]);
            vecCount++;
            if ({read_valid, ram_out} !== {1'b1, 32'h0}) begin
                missCount++;
                $display("[TB] FAIL post_clear[%0d]: got rv=%b out=%h expected rv=1 out=00000000",
                         addrs[i], read_valid, ram_out);
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        do_write(6'd3, 32'h0BADF00D, 4'b1111);
        do_read(6'd3);
        vecCount++;
        if (ram_out !== 32'h0BADF00D) begin
            missCount++;
            $display("[TB] FAIL pre_reset_read: got %h expected 0badf00d", ram_out);
        end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (30) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        vecCount++;
        if ({busy, read_valid, ram_out} !== {1'b1, 1'b0, 32'h0}) begin
            missCount++;
            $display("[TB] FAIL async_reset: got busy=%b rv=%b out=%h expected busy=1 rv=0 out=00000000",
                     busy, read_valid, ram_out);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        count_busy(n);
        vecCount++;
        if (n !== 64) begin
            missCount++;
            $display("[TB] FAIL rereset_busy_len: got %0d expected 64", n);
        end
        do_read(6'd3);
        vecCount++;
        if ({read_valid, ram_out} !== {1'b1, 32'h0}) begin
            missCount++;
            $display("[TB] FAIL rereset_read: got rv=%b out=%h expected rv=1 out=00000000", read_valid, ram_out);
        end
    endtask

    initial begin
        test_reset;
        test_clear_contents;
        test_byte_write;
        test_zero_mask;
        test_forwarding;
        test_independent;
        test_clear_pulse;
        test_reset_mid_clear;
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 6: address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Port clock  input  1: single clock; all state SHALL change on its rising edge except at reset.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port clear  input  1: one-cycle request to zero the whole memory.
REQ-006 Port we  input  1: write enable.
REQ-007 Port byte_en  input  DATA_WIDTH/8: per-byte write mask; bit i selects data[8i+7:8i].
REQ-008 Port write_addr  input  ADDR_WIDTH: write address.
REQ-009 Port data  input  DATA_WIDTH: write data.
REQ-010 Port re  input  1: read enable.
REQ-011 Port read_addr  input  ADDR_WIDTH: read address.
REQ-012 Port ram_out  output  DATA_WIDTH: registered read data.
REQ-013 Port read_valid  output  1: ram_out updated by a read accepted on the previous edge.
REQ-014 Port busy  output  1: clear sequence in progress; user accesses are ignored.

Function
REQ-015 The FSM SHALL have two states, CLEAR and IDLE; busy SHALL be 1 exactly in CLEAR.
REQ-016 In CLEAR, a clear counter SHALL write all-zero to address counter on every edge, from 0 up to 2**ADDR_WIDTH-1, taking exactly 2**ADDR_WIDTH cycles.
REQ-017 CLEAR SHALL go to IDLE on the edge that writes the last address, with the counter wrapping to 0; busy SHALL be 0 from the next cycle.
REQ-018 In IDLE, clear=1 SHALL enter CLEAR with the counter at 0; in that same cycle we and re SHALL be ignored.
REQ-019 clear asserted while in CLEAR SHALL be ignored; the sequence SHALL neither restart nor extend.
REQ-020 In IDLE, with we=1, each byte lane i with byte_en[i]=1 SHALL be written from data at write_addr; lanes with byte_en[i]=0 SHALL keep their value.
REQ-021 we=1 with byte_en all zero SHALL leave the memory unchanged.
REQ-022 In IDLE, re=1 SHALL load ram_out with the word at read_addr on the same edge; read latency is 1 cycle.
REQ-023 read_valid SHALL be 1 for exactly the cycle after each accepted read, and 0 otherwise.
REQ-024 When re=0, or while busy=1, ram_out SHALL hold its last value and read_valid SHALL be 0.
REQ-025 Read and write to the same address on the same edge SHALL return the new word: written lanes from data, unwritten lanes from the old memory contents (write-first forwarding).
REQ-026 Read and write to different addresses on the same edge SHALL proceed independently.
REQ-027 In CLEAR, we and re SHALL be ignored: no memory write from user ports, and no read_valid.

Reset
REQ-028 While reset_n=0: ram_out=0, read_valid=0, busy=1, state=CLEAR, clear counter=0, asynchronously.
REQ-029 After reset_n rises, the full clear sequence SHALL run; the first user access SHALL be accepted 2**ADDR_WIDTH cycles after the first rising edge with reset_n=1.
REQ-030 Reset asserted mid-CLEAR or mid-operation SHALL abort all activity; the clear sequence SHALL restart from address 0.
REQ-031 Memory contents are not reset directly; they SHALL be zero only through the clear sequence.

Verification
REQ-032 Reset release, ADDR_WIDTH=6 -> busy=1 for exactly 64 cycles; reads of all 64 addresses afterwards return 0x00000000.
REQ-033 Write 0xDEADBEEF to addr 5 with byte_en=4'b1111, then with data 0x11223344 and byte_en=4'b0101; read addr 5 -> ram_out=0xDE22BE44 one cycle after re, read_valid high for 1 cycle.
REQ-034 Same-edge write 0xCAFEF00D (byte_en=4'b0011) and read, both at addr 9, old contents 0x12345678 -> ram_out=0x1234F00D.
REQ-035 In IDLE, pulse clear -> busy high for 64 cycles; we/re during busy have no effect and read_valid stays 0; addr 5 reads 0 afterwards.
REQ-036 reset_n pulsed low at clear counter 30 -> outputs go to reset values at once; after release, busy lasts a full 64 cycles.
